// File: rtl/baud_pkg.sv
// baud_pkg -- shared constants and helpers for the baud tick generator.
//   DEF_*          : default parameter values for baud_tick_gen
//   MIN_DIV        : smallest integer divisor accepted at runtime
//   ovs_is_legal() : oversample-ratio check (8 or 16)
//   calc_div()     : rounded clk cycles per oversample tick for a given baud
package baud_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_FRAC_W  = 4;
    localparam int DEF_OVS     = 16;
    localparam int DEF_DIV_VAL = 326;   // 50 MHz / (9600 * 16), rounded
    localparam int MIN_DIV     = 2;

    function automatic bit ovs_is_legal(input int ovs);
        return (ovs == 8) || (ovs == 16);
    endfunction

    // Nearest integer divisor; returns 0 for a zero baud or ratio.
    function automatic int calc_div(input longint unsigned clk_hz,
                                    input longint unsigned baud,
                                    input int unsigned     ovs);
        longint unsigned step;
        step = baud * longint'(ovs);
        if (step == 0)
            return 0;
        return int'((clk_hz + step / 2) / step);
    endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if -- control/status bundle of the baud tick generator.
//   master : drives en, sync_clr, div_int, div_frac, div_load; observes ticks
//   slave  : the generator side (baud_tick_gen)
interface baud_tick_gen_if
    import baud_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OVS    = DEF_OVS
) ();
    localparam int PH_W = $clog2(OVS);

    logic              en;
    logic              sync_clr;
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_ack;
    logic              cfg_err;
    logic              os_tick;
    logic              bit_tick;
    logic [PH_W-1:0]   ovs_phase;

    modport master (
        output en, sync_clr, div_int, div_frac, div_load,
        input  div_ack, cfg_err, os_tick, bit_tick, ovs_phase
    );

    modport slave (
        input  en, sync_clr, div_int, div_frac, div_load,
        output div_ack, cfg_err, os_tick, bit_tick, ovs_phase
    );
endinterface

// File: rtl/baud_div_cnt.sv
// baud_div_cnt -- period counter for the baud tick generator.
//   clk, reset (sync, active-low), en, sync_clr
//   div  : active integer divisor D
//   frac : active fractional divisor (only with BAUD_FRAC_DIV_EN)
//   wrap : combinational; high when the current edge closes a period
// With BAUD_FRAC_DIV_EN defined, a FRAC_W-bit accumulator adds frac at every
// period boundary and a carry out stretches the following period by one cycle.
module baud_div_cnt #(
    parameter int CNT_W  = 16
`ifdef BAUD_FRAC_DIV_EN
  , parameter int FRAC_W = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync_clr,
    input  logic [CNT_W-1:0]  div,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [FRAC_W-1:0] frac,
`endif
    output logic              wrap
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] acc;
    logic              ext;     // current period is D+1 cycles
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac};
    assign target  = ext ? div : div - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset || sync_clr) begin
            acc <= '0;
            ext <= 1'b0;
        end else if (wrap) begin
            acc <= acc_sum[FRAC_W-1:0];
            ext <= acc_sum[FRAC_W];
        end
    end
`else
    assign target = div - CNT_W'(1);
`endif

    // >= rather than ==: a divisor swapped in while idle may sit below the
    // count already reached, and the period must close instead of wrapping.
    assign wrap = en && !sync_clr && (cnt >= target);

    always_ff @(posedge clk) begin
        if (!reset || sync_clr)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen -- UART oversample/bit tick generator.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : baud_tick_gen_if.slave
//           in : en, sync_clr, div_int, div_frac, div_load
//           out: div_ack, cfg_err, os_tick, bit_tick, ovs_phase (all registered)
// Optional feature macro: BAUD_FRAC_DIV_EN enables the fractional divisor;
// without it div_frac is ignored and every period is exactly D cycles.
// Divisor requests are parked in a pending register and only swapped in at
// a period boundary (or immediately while idle) so no period is truncated.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int OVS     = DEF_OVS,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic clk,
    input  logic reset,
    baud_tick_gen_if.slave bus
);
    // An unsupported ratio falls back to the default wrap point.
    localparam int              OVS_EFF = ovs_is_legal(OVS) ? OVS : DEF_OVS;
    localparam int              PH_W    = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS_EFF - 1);

    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic             pend_vld;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;
    logic             activate;

    assign load_ok  = bus.div_load && (bus.div_int >= CNT_W'(MIN_DIV));
    assign load_bad = bus.div_load && !load_ok;
    // While idle there is no boundary to wait for, so swap on the next edge.
    assign activate = pend_vld && (wrap || !bus.en);

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] frac_act;
    logic [FRAC_W-1:0] frac_pend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frac_act  <= '0;
            frac_pend <= '0;
        end else begin
            if (activate)
                frac_act <= frac_pend;
            if (load_ok)
                frac_pend <= bus.div_frac;
        end
    end

    baud_div_cnt #(.CNT_W(CNT_W), .FRAC_W(FRAC_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .sync_clr (bus.sync_clr),
        .div      (div_act),
        .frac     (frac_act),
        .wrap     (wrap)
    );
`else
    logic [FRAC_W-1:0] unused_div_frac;
    assign unused_div_frac = bus.div_frac;

    baud_div_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .sync_clr (bus.sync_clr),
        .div      (div_act),
        .wrap     (wrap)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_act       <= CNT_W'(DEF_DIV);
            div_pend      <= '0;
            pend_vld      <= 1'b0;
            bus.div_ack   <= 1'b0;
            bus.cfg_err   <= 1'b0;
            bus.os_tick   <= 1'b0;
            bus.bit_tick  <= 1'b0;
            bus.ovs_phase <= '0;
        end else begin
            bus.div_ack  <= activate;
            bus.cfg_err  <= load_bad;
            bus.os_tick  <= wrap;
            bus.bit_tick <= wrap && (bus.ovs_phase == PH_LAST);

            if (activate) begin
                div_act  <= div_pend;
                pend_vld <= 1'b0;
            end
            // A newer request overrides both the pending one and the clear.
            if (load_ok) begin
                div_pend <= bus.div_int;
                pend_vld <= 1'b1;
            end

            if (bus.sync_clr)
                bus.ovs_phase <= '0;
            else if (wrap)
                bus.ovs_phase <= (bus.ovs_phase == PH_LAST) ? '0
                                                            : bus.ovs_phase + PH_W'(1);
        end
    end
endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the integer divisor and the cycle counter.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor and the accumulator.
REQ-003 Parameter OVS, default 16: oversample ticks per bit, legal values 8 or 16.
REQ-004 Parameter DEF_DIV, default 326: integer divisor in effect after reset.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  tick generation enable.
REQ-008 sync_clr  in  1  phase restart pulse, used for RX start-bit alignment.
REQ-009 div_int  in  CNT_W  requested integer divisor, in clk cycles per os_tick.
REQ-010 div_frac  in  FRAC_W  requested fractional divisor, in units of 1/2^FRAC_W cycle.
REQ-011 div_load  in  1  1-cycle strobe that requests a divisor change.
REQ-012 div_ack  out  1  1-cycle pulse in the cycle the requested divisor takes effect.
REQ-013 cfg_err  out  1  1-cycle pulse when a divisor request is rejected.
REQ-014 os_tick  out  1  1-cycle oversample tick for the receiver.
REQ-015 bit_tick  out  1  1-cycle bit tick for the transmitter.
REQ-016 ovs_phase  out  $clog2(OVS)  index of the current oversample tick within the bit.

Function
REQ-017 All outputs SHALL be registered, and every tick SHALL be a single-cycle pulse, never a toggle.
REQ-018 With en=1, the os_tick period SHALL be D cycles, where D is the active integer divisor; the first os_tick SHALL occur in the D-th enabled cycle after a restart.
REQ-019 On every os_tick, ovs_phase SHALL increment, wrapping from OVS-1 to 0.
REQ-020 bit_tick SHALL assert in the same cycle as an os_tick that occurs while ovs_phase==OVS-1.
REQ-021 With en=0, the counter, accumulator and ovs_phase SHALL hold, and no ticks SHALL be produced.
REQ-022 sync_clr=1 SHALL clear the counter, accumulator and ovs_phase to 0 and suppress all ticks that cycle; sync_clr SHALL take priority over en.
REQ-023 A div_load with div_int>=2 SHALL be captured into a pending register one cycle later; a later div_load SHALL overwrite a pending request.
REQ-024 A pending divisor SHALL become active at the first os_tick boundary after capture, or in the next cycle if en=0, with div_ack pulsing in that cycle.
REQ-025 The new divisor SHALL govern the period that starts after div_ack; the period in progress SHALL never be truncated.
REQ-026 A div_load with div_int<2 SHALL be discarded, and cfg_err SHALL pulse in the following cycle.
REQ-027 The counter SHALL compare against D-1 at CNT_W width, so div_int of all ones is legal and no wrap-around occurs.

Reset
REQ-028 While reset=0 at a clock edge, the following SHALL be cleared or loaded on that edge:
- counter, accumulator, ovs_phase and the pending flag cleared to 0;
- active divisor loaded with DEF_DIV and fractional divisor 0;
- all outputs cleared to 0.
REQ-029 A reset asserted mid-period or with a request pending SHALL discard the pending request without a div_ack pulse.

Configuration
REQ-030 With macro BAUD_FRAC_DIV_EN defined, the following SHALL apply:
- A FRAC_W-bit accumulator SHALL add div_frac on each os_tick.
- Each period following a carry out SHALL last D+1 cycles.
- The mean period SHALL be D + div_frac/2^FRAC_W cycles.
REQ-031 Without BAUD_FRAC_DIV_EN, the following SHALL apply:
- div_frac SHALL remain a port but be ignored.
- No accumulator SHALL exist.
- Every period SHALL be exactly D cycles.

Structure
REQ-032 Package baud_pkg SHALL hold the following:
- default parameter constants;
- the legal-OVS check;
- a function computing the divisor from clock and baud frequencies.
REQ-033 Sub-module baud_div_cnt SHALL implement the counter and fractional accumulator and emit the os_tick boundary; the top level SHALL own the divisor handshake and the ovs_phase/bit_tick logic.

Verification
REQ-034 Reset, then en=1 with DEF_DIV=326 -> first os_tick in cycle 326, period 326, bit_tick every 5216 cycles, ovs_phase cycling 0..15.
REQ-035 With BAUD_FRAC_DIV_EN, div_int=325 and div_frac=8 -> periods alternate 325/326, and 16 os_ticks span exactly 5208 cycles.
REQ-036 div_load with div_int=100 at mid-period -> the current 326-cycle period completes, div_ack coincides with that os_tick, and the next period is 100 cycles.
REQ-037 div_load with div_int=1 -> cfg_err pulses 1 cycle later, no div_ack, and the period is unchanged.
REQ-038 sync_clr at ovs_phase=9, then en held low for 50 cycles -> phase returns to 0 with no tick on the sync_clr cycle; no ticks during the hold, and the count resumes intact afterwards.
REQ-039 reset=0 asserted with a request pending -> all outputs 0 on the next edge, and DEF_DIV is restored with no div_ack.
